// File: rtl/data_gen_two64_pkg.sv
//==============================================================================
// Module : data_gen_pkg
// Brief  : Shared widths and FSM state type for the two-lane pattern generator.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package data_gen_pkg;
    localparam int LANE_W = 64;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_t;
endpackage

`default_nettype wire

// File: rtl/data_gen_two64_if.sv
//==============================================================================
// Module : data_gen_two64_if
// Brief  : Valid/ready user TX beat interface (128-bit data, two 64-bit lanes).
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface data_gen_two64_if;
    import data_gen_pkg::*;

    logic [DATA_W-1:0] usr_tx;
    logic              usr_tx_valid;
    logic              usr_tx_ready;

    modport master (
        output usr_tx,
        output usr_tx_valid,
        input  usr_tx_ready
    );

    modport slave (
        input  usr_tx,
        input  usr_tx_valid,
        output usr_tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/data_gen_two64_lane_inc.sv
//==============================================================================
// Module : lane_inc
// Brief  : One 64-bit lane register: seed on reset, add STEP when enabled.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module lane_inc
    import data_gen_pkg::*;
#(
    parameter logic [LANE_W-1:0] SEED = '0,
    parameter logic [LANE_W-1:0] STEP = 64'h2
) (
    input  wire logic              clk_usr,
    input  wire logic              rst_n,
    input  wire logic              step_en,
    output logic [LANE_W-1:0]      value
);
    logic [LANE_W-1:0] value_q;
    logic [LANE_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (step_en) begin
            value_d = value_q + STEP;
        end
    end

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

`default_nettype wire

// File: rtl/data_gen_two64.sv
//==============================================================================
// Module : data_gen_two64
// Brief  : Two-lane incrementing TX test-pattern generator, bursts with gaps.
//          Optional error injection enabled by defining DATA_GEN_ERR_INJ_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module data_gen_two64
    import data_gen_pkg::*;
#(
    parameter logic [LANE_W-1:0] DATA_INTERVAL = 64'h2,
    parameter logic [LANE_W-1:0] LANE0_SEED    = 64'h0,
    parameter logic [LANE_W-1:0] LANE1_SEED    = 64'h0,
    parameter int unsigned       BURST_LEN     = 256,
    parameter int unsigned       GAP_CYCLES    = 4
) (
    input  wire logic        clk_usr,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic        stop,
    input  wire logic        continuous,
    data_gen_two64_if.master tx,
    output logic             busy,
    output logic             done,
    output logic [31:0]      beat_cnt
`ifdef DATA_GEN_ERR_INJ_EN
    ,
    input  wire logic        err_inj,
    output logic [15:0]      err_inj_cnt
`endif
);
    localparam logic [31:0] BURST_LAST = (BURST_LEN  > 1) ? 32'(BURST_LEN - 1)  : 32'd0;
    localparam logic [31:0] GAP_LAST   = (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 1) : 32'd0;

    gen_state_t        state_q, state_d;
    logic [31:0]       burst_cnt_q, burst_cnt_d;
    logic [31:0]       gap_cnt_q, gap_cnt_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic              done_q, done_d;
    logic              sending;
    logic              accept;
    logic [LANE_W-1:0] lane0_val;
    logic [LANE_W-1:0] lane1_val;

    assign sending = (state_q == SEND);
    assign accept  = sending && tx.usr_tx_ready;

    lane_inc #(.SEED(LANE0_SEED), .STEP(DATA_INTERVAL)) u_lane0 (
        .clk_usr (clk_usr),
        .rst_n   (rst_n),
        .step_en (accept),
        .value   (lane0_val)
    );

    lane_inc #(.SEED(LANE1_SEED), .STEP(DATA_INTERVAL)) u_lane1 (
        .clk_usr (clk_usr),
        .rst_n   (rst_n),
        .step_en (accept),
        .value   (lane1_val)
    );

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = '0;
        beat_cnt_d  = accept ? (beat_cnt_q + 32'd1) : beat_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        // Burst end is the only point where stop/continuous are honoured.
                        burst_cnt_d = '0;
                        if (stop || !continuous) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 32'd1;
                    end
                end
            end
            GAP: begin
                burst_cnt_d = '0;
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx.usr_tx_valid = sending;
        busy            = (state_q != IDLE);
        done            = done_q;
        beat_cnt        = beat_cnt_q;
    end

`ifdef DATA_GEN_ERR_INJ_EN
    // inj_cur marks the beat on the bus as corrupted; pend holds a pulse seen
    // during a stall so the held beat is not altered.
    logic        inj_cur_q, inj_cur_d;
    logic        inj_pend_q, inj_pend_d;
    logic [15:0] inj_cnt_q, inj_cnt_d;

    always_comb begin
        inj_cur_d  = inj_cur_q;
        inj_pend_d = inj_pend_q;
        inj_cnt_d  = inj_cnt_q;
        if (!sending) begin
            inj_cur_d  = inj_cur_q | inj_pend_q | err_inj;
            inj_pend_d = 1'b0;
        end else if (accept) begin
            inj_cur_d  = inj_pend_q | err_inj;
            inj_pend_d = 1'b0;
            if (inj_cur_q && (inj_cnt_q != 16'hFFFF)) begin
                inj_cnt_d = inj_cnt_q + 16'd1;
            end
        end else begin
            inj_pend_d = inj_pend_q | err_inj;
        end
    end

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            inj_cur_q  <= 1'b0;
            inj_pend_q <= 1'b0;
            inj_cnt_q  <= '0;
        end else begin
            inj_cur_q  <= inj_cur_d;
            inj_pend_q <= inj_pend_d;
            inj_cnt_q  <= inj_cnt_d;
        end
    end

    assign tx.usr_tx    = {lane1_val, lane0_val ^ {{(LANE_W-1){1'b0}}, inj_cur_q}};
    assign err_inj_cnt  = inj_cnt_q;
`else
    assign tx.usr_tx    = {lane1_val, lane0_val};
`endif
endmodule

`default_nettype wire

// File: tb/tb_data_gen_two64.sv
//==============================================================================
// Module : tb_data_gen_two64
// Brief  : Self-checking bench for data_gen_two64 (vector table plus sequences).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_data_gen_two64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Main instance: BURST_LEN=4, GAP_CYCLES=4, lane1 offset from lane0 by 0x1000.
    logic        start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic        busy, done;
    logic [31:0] beat_cnt;
    data_gen_two64_if u_if();

    // Wrap instance: lane0 near 2^64, single-beat bursts, no gap.
    logic        start_w = 1'b0, stop_w = 1'b0, cont_w = 1'b0;
    logic        busy_w, done_w;
    logic [31:0] beat_cnt_w;
    data_gen_two64_if u_if_w();

`ifdef DATA_GEN_ERR_INJ_EN
    logic        err_inj = 1'b0, err_inj_w = 1'b0;
    logic [15:0] err_inj_cnt, err_inj_cnt_w;
`endif

    data_gen_two64 #(
        .DATA_INTERVAL (64'h2),
        .LANE0_SEED    (64'h0),
        .LANE1_SEED    (64'h1000),
        .BURST_LEN     (4),
        .GAP_CYCLES    (4)
    ) dut (
        .clk_usr    (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (cont),
        .tx         (u_if.master),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt)
`ifdef DATA_GEN_ERR_INJ_EN
        ,
        .err_inj     (err_inj),
        .err_inj_cnt (err_inj_cnt)
`endif
    );

    data_gen_two64 #(
        .DATA_INTERVAL (64'h2),
        .LANE0_SEED    (64'hFFFF_FFFF_FFFF_FFFE),
        .LANE1_SEED    (64'h5),
        .BURST_LEN     (1),
        .GAP_CYCLES    (0)
    ) dut_w (
        .clk_usr    (clk),
        .rst_n      (rst_n),
        .start      (start_w),
        .stop       (stop_w),
        .continuous (cont_w),
        .tx         (u_if_w.master),
        .busy       (busy_w),
        .done       (done_w),
        .beat_cnt   (beat_cnt_w)
`ifdef DATA_GEN_ERR_INJ_EN
        ,
        .err_inj     (err_inj_w),
        .err_inj_cnt (err_inj_cnt_w)
`endif
    );

    typedef struct {
        logic        start, stop, cont, ready;
        logic        exp_valid, exp_busy, exp_done;
        logic [63:0] exp_l0;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic p, input logic c, input logic r,
                       input logic v, input logic b, input logic d,
                       input logic [63:0] l0, input logic [31:0] n);
        vec_t e;
        e.start = s; e.stop = p; e.cont = c; e.ready = r;
        e.exp_valid = v; e.exp_busy = b; e.exp_done = d;
        e.exp_l0 = l0; e.exp_cnt = n;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] exp_l0;
        logic [31:0] exp_cnt;
        logic        r, prev_stall, got_done;

        // start stop cont ready | valid busy done lane0 beat_cnt
        add(0,0,0,1, 0,0,0, 64'd0,  0);
        add(1,0,0,1, 0,0,0, 64'd0,  0);
        add(0,0,0,1, 1,1,0, 64'd0,  0);
        add(0,0,0,1, 1,1,0, 64'd2,  1);
        add(0,0,0,0, 1,1,0, 64'd4,  2);
        add(0,0,0,0, 1,1,0, 64'd4,  2);
        add(0,0,0,1, 1,1,0, 64'd4,  2);
        add(0,0,0,1, 1,1,0, 64'd6,  3);
        add(0,0,0,1, 0,0,1, 64'd8,  4);
        add(1,1,1,1, 0,0,0, 64'd8,  4);   // start+stop in IDLE: one burst
        add(0,1,1,1, 1,1,0, 64'd8,  4);
        add(0,1,1,1, 1,1,0, 64'd10, 5);
        add(0,1,1,1, 1,1,0, 64'd12, 6);
        add(0,1,1,1, 1,1,0, 64'd14, 7);
        add(0,0,1,1, 0,0,1, 64'd16, 8);
        add(1,0,1,1, 0,0,0, 64'd16, 8);   // continuous run
        for (int i = 0; i < 4; i++) add(0,0,1,1, 1,1,0, 64'(16 + 2*i), 32'(8 + i));
        for (int i = 0; i < 4; i++) add(0,0,1,1, 0,1,0, 64'd24, 12);
        add(0,1,1,0, 1,1,0, 64'd24, 12);  // stop raised on a stalled first beat
        add(0,1,1,1, 1,1,0, 64'd24, 12);
        add(0,1,1,1, 1,1,0, 64'd26, 13);
        add(0,1,1,1, 1,1,0, 64'd28, 14);
        add(0,1,1,1, 1,1,0, 64'd30, 15);
        add(0,0,1,1, 0,0,1, 64'd32, 16);
        add(1,0,1,1, 0,0,0, 64'd32, 16);
        for (int i = 0; i < 4; i++) add(0,0,1,1, 1,1,0, 64'(32 + 2*i), 32'(16 + i));
        add(0,1,1,1, 0,1,0, 64'd40, 20);  // stop seen in GAP
        add(0,0,0,1, 0,0,1, 64'd40, 20);
        add(0,0,0,1, 0,0,0, 64'd40, 20);

        u_if.usr_tx_ready   = 1'b1;
        u_if_w.usr_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            chk($sformatf("v%0d_valid", k), 128'(u_if.usr_tx_valid), 128'(vecs[k].exp_valid));
            chk($sformatf("v%0d_busy", k),  128'(busy),              128'(vecs[k].exp_busy));
            chk($sformatf("v%0d_done", k),  128'(done),              128'(vecs[k].exp_done));
            chk($sformatf("v%0d_cnt", k),   128'(beat_cnt),          128'(vecs[k].exp_cnt));
            chk($sformatf("v%0d_data", k),  u_if.usr_tx,
                {vecs[k].exp_l0 + 64'h1000, vecs[k].exp_l0});
            start = vecs[k].start; stop = vecs[k].stop; cont = vecs[k].cont;
            u_if.usr_tx_ready = vecs[k].ready;
        end

        // Continuous run with random ready; data must track the model while held.
        exp_l0 = 64'd40; exp_cnt = 32'd20; prev_stall = 1'b0; got_done = 1'b0;
        @(negedge clk); start = 1'b1; cont = 1'b1; stop = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 400 + 100 && !got_done; c++) begin
            if (c == 400) stop = 1'b1;
            if (c > 0) @(negedge clk);
            if (prev_stall) chk("rnd_hold_valid", 128'(u_if.usr_tx_valid), 128'd1);
            chk("rnd_cnt", 128'(beat_cnt), 128'(exp_cnt));
            if (u_if.usr_tx_valid) chk("rnd_data", u_if.usr_tx, {exp_l0 + 64'h1000, exp_l0});
            if (done) got_done = 1'b1;
            r = 1'($urandom_range(0, 1));
            u_if.usr_tx_ready = r;
            if (u_if.usr_tx_valid && r) begin
                exp_l0  = exp_l0 + 64'd2;
                exp_cnt = exp_cnt + 32'd1;
            end
            prev_stall = u_if.usr_tx_valid && !r;
        end
        chk("rnd_stop_done", 128'(got_done), 128'd1);
        stop = 1'b0; cont = 1'b0;

        // Asynchronous reset mid-burst.
        @(negedge clk); start = 1'b1; u_if.usr_tx_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(u_if.usr_tx_valid), 128'd0);
        chk("arst_busy",  128'(busy),              128'd0);
        chk("arst_cnt",   128'(beat_cnt),          128'd0);
        chk("arst_data",  u_if.usr_tx,             {64'h1000, 64'h0});
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_done", 128'(done), 128'd0);
        chk("arst_idle",    128'(busy), 128'd0);

        // Lane0 wrap, lane1 independent, GAP_CYCLES=0 back-to-back bursts.
        chk("w_seed", u_if_w.usr_tx, {64'h5, 64'hFFFF_FFFF_FFFF_FFFE});
        start_w = 1'b1; cont_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        chk("w_b1_valid", 128'(u_if_w.usr_tx_valid), 128'd1);
        chk("w_b1_data",  u_if_w.usr_tx, {64'h5, 64'hFFFF_FFFF_FFFF_FFFE});
        @(negedge clk);
        chk("w_b2_valid", 128'(u_if_w.usr_tx_valid), 128'd1);
        chk("w_wrap",     u_if_w.usr_tx, {64'h7, 64'h0});
        chk("w_cnt1",     128'(beat_cnt_w), 128'd1);
        stop_w = 1'b1;
        @(negedge clk);
        chk("w_end_valid", 128'(u_if_w.usr_tx_valid), 128'd0);
        chk("w_end_done",  128'(done_w), 128'd1);
        chk("w_end_data",  u_if_w.usr_tx, {64'h9, 64'h2});
        chk("w_cnt2",      128'(beat_cnt_w), 128'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
